grf_mp: RTL and testbench
=========================

Name: grf_mp

Overview:
- Parametrised general register file for the pipelined MIPS datapath; successor to the single-cycle 2-read/1-write GRF.
- Adds a configurable number of read ports and byte-enable writes.
- Adds same-cycle write-to-read forwarding, so the decode stage sees writeback data without external bypass muxes.
- Adds a per-register pending-write scoreboard, so hazard logic can stall on in-flight producers.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- AW, 5, address width; register count NREG = 2**AW.
- NRD, 2, number of independent read ports (1..4).
- LOG_EN, 1, when 1, every committed write emits a simulation trace line.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- rd_addr  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*DW  packed read data, combinational.
- rd_busy  out  NRD  per-port flag: addressed register has a pending write.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  DW  write data.
- wbe  in  DW/8  byte enables; byte b written when wbe[b]=1.
- wpc  in  32  PC of the writing instruction; used only for trace.
- iss_valid  in  1  an instruction that will write iss_addr is issued this cycle.
- iss_addr  in  AW  destination register of the issued instruction.
- pend_flush  in  1  clear all pending flags (pipeline flush).
- pend_cnt  out  AW+1  number of registers currently marked pending, registered.

Behaviour:
- Reset, asynchronous:
  - All NREG registers are cleared to 0.
  - All pending flags are cleared; pend_cnt = 0.
  - Hence rd_data = 0 and rd_busy = 0 on every port while reset is high.
  - A write, issue or flush coinciding with reset is ignored.
- Register 0:
  - Always reads 0 and is never pending.
  - Writes and issues with address 0 are dropped; no trace line, no pending flag, no forwarding.
- Write at posedge clk when we=1 and wa!=0:
  - Each byte b with wbe[b]=1 takes wd byte b; the other bytes keep their old value.
  - wbe all-zero: no state change and no trace line.
- Read (combinational) for port k, with ra = rd_addr slice:
  - ra=0 -> rd_data = 0.
  - we=1, wa==ra, ra!=0 -> forward the merged value: per byte, wbe ? wd : stored.
  - Otherwise -> stored value.
  - Read-during-write therefore has 0-cycle latency; every port forwards independently.
- Trace: when LOG_EN=1 and a write commits, emit `@<wpc hex>: $<wa dec> <= <merged value hex>` at that edge.
- Scoreboard, updated at posedge clk, in priority order:
  - pend_flush=1 -> all flags are cleared; iss_valid and the clear-on-write in the same cycle are ignored.
  - Write commit (we=1, wa!=0, any wbe bit set) -> pending[wa] is cleared.
  - iss_valid=1 with iss_addr!=0 -> pending[iss_addr] is set.
  - Issue and write to the same address in the same cycle -> set wins (a new producer supersedes the old one).
  - Issue to an address that is already pending -> stays pending; no count change.
- rd_busy[k]:
  - Equals pending[ra], except 0 when a write to ra commits this cycle and iss_valid does not target ra.
  - This matches forwarding: data being written is available now.
- pend_cnt:
  - Registered popcount of the pending flags, updated in the same edge as the flags.
  - Range 0..NREG-1; cannot overflow because register 0 is excluded.

Decomposition:
- Shared package `grf_pkg`: DW/AW defaults, NREG, zero-register index constant, and a byte-merge function (old, new, be) -> merged.
- One natural sub-module: `grf_scoreboard` (pending flags, set/clear/flush priority, popcount).
- The data array, forwarding muxes and trace stay in the top level.

Test Plan:
- Reset mid-operation: after writes, assert reset asynchronously between edges -> all rd_data read 0, pend_cnt=0 immediately, without waiting for an edge.
- Forwarding: write $5=0x12345678 with wbe=F; in the next cycle write $5=0xAABBCCDD with wbe=0101b while port 0 and port 1 both read $5 -> both show 0x12BB56DD combinationally; stored value is 0x12BB56DD after the edge; trace line `$ 5 <= 12bb56dd`.
- Zero register: we=1, wa=0, wd=0xFFFFFFFF plus iss_valid for $0 -> rd_data 0, no trace line, pend_cnt unchanged.
- Scoreboard: issue $3, then issue $7 -> pend_cnt=2 and rd_busy set for $3 readers; write $3 -> busy drops in the write cycle, pend_cnt=1 next cycle.
- Simultaneous events:
  - Issue $9 and write $9 in the same cycle -> $9 stays pending and data is updated.
  - pend_flush together with iss_valid for $4 -> pend_cnt=0.
- Parameter sweep: DW=64, AW=4, NRD=3 -> 8-bit wbe honoured; ports read independently with no cross-talk; maximum pend_cnt = 15.

Source files
------------

// File: rtl/grf_pkg.sv
// rtl/grf_pkg.sv - shared constants and byte-merge helper for the register file
package grf_pkg;

    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;
    localparam int NREG_DEF = 2 ** AW_DEF;
    localparam int ZERO_REG = 0;

    // Widest data word the merge helper handles; callers extend and truncate.
    localparam int MAX_DW = 512;
    localparam int MAX_BE = MAX_DW / 8;

    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0] old_v,
        input logic [MAX_DW-1:0] new_v,
        input logic [MAX_BE-1:0] be
    );
        logic [MAX_DW-1:0] m;
        m = old_v;
        for (int b = 0; b < MAX_BE; b++) begin
            if (be[b]) begin
                m[b*8 +: 8] = new_v[b*8 +: 8];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/grf_mp_if.sv
// rtl/grf_mp_if.sv - read, write, issue and trace bundle of the register file
interface grf_mp_if
    import grf_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int AW  = AW_DEF,
    parameter int NRD = 2
);

    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;

    logic              we;
    logic [AW-1:0]     wa;
    logic [DW-1:0]     wd;
    logic [DW/8-1:0]   wbe;
    logic [31:0]       wpc;

    logic              iss_valid;
    logic [AW-1:0]     iss_addr;
    logic              pend_flush;
    logic [AW:0]       pend_cnt;

    // Committed-write trace record, one per write edge
    logic              log_valid;
    logic [31:0]       log_pc;
    logic [AW-1:0]     log_addr;
    logic [DW-1:0]     log_data;

    modport master (
        output rd_addr, we, wa, wd, wbe, wpc, iss_valid, iss_addr, pend_flush,
        input  rd_data, rd_busy, pend_cnt, log_valid, log_pc, log_addr, log_data
    );

    modport slave (
        input  rd_addr, we, wa, wd, wbe, wpc, iss_valid, iss_addr, pend_flush,
        output rd_data, rd_busy, pend_cnt, log_valid, log_pc, log_addr, log_data
    );

endinterface

// File: rtl/grf_scoreboard.sv
// rtl/grf_scoreboard.sv - per-register pending-write flags with registered popcount
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              clr_valid_i,
    input  logic [AW-1:0]     clr_addr_i,
    input  logic              set_valid_i,
    input  logic [AW-1:0]     set_addr_i,
    output logic [2**AW-1:0]  pending_o,
    output logic [AW:0]       pend_cnt_o
);

    localparam int NREG = 2 ** AW;

    logic [NREG-1:0] pending_q, pending_d;
    logic [AW:0]     cnt_q, cnt_d;

    // Flush beats everything; a same-cycle set beats the clear from a write.
    always_comb begin
        pending_d = pending_q;
        if (flush_i) begin
            pending_d = '0;
        end else begin
            if (clr_valid_i) begin
                pending_d[clr_addr_i] = 1'b0;
            end
            if (set_valid_i) begin
                pending_d[set_addr_i] = 1'b1;
            end
        end
        pending_d[ZERO_REG] = 1'b0;

        cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, pending_d[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending_o  = pending_q;
    assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/grf_mp.sv
// rtl/grf_mp.sv - multi-port register file with byte enables, forwarding and scoreboard
module grf_mp
    import grf_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int NRD    = 2,
    parameter int LOG_EN = 1
) (
    input  logic      clk,
    input  logic      reset,
    grf_mp_if.slave   bus
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0]   mem_q [NREG];
    logic [NREG-1:0] pending;
    logic            wr_commit;
    logic            iss_hit;
    logic [DW-1:0]   merged_d;

    // Gating with reset keeps forwarded data at zero while reset is held.
    assign wr_commit = bus.we && (bus.wa != AW'(ZERO_REG)) && (|bus.wbe) && !reset;
    assign iss_hit   = bus.iss_valid && (bus.iss_addr != AW'(ZERO_REG)) && !reset;

    assign merged_d = DW'(byte_merge(MAX_DW'(mem_q[bus.wa]), MAX_DW'(bus.wd),
                                     MAX_BE'(bus.wbe)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_commit) begin
            mem_q[bus.wa] <= merged_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          fwd;
        assign ra  = bus.rd_addr[k*AW +: AW];
        assign fwd = wr_commit && (bus.wa == ra);

        assign bus.rd_data[k*DW +: DW] = (ra == AW'(ZERO_REG)) ? '0 :
                                         fwd                   ? merged_d :
                                                                 mem_q[ra];

        // A write landing now satisfies the reader unless a new producer replaces it.
        assign bus.rd_busy[k] = pending[ra] &&
                                !(fwd && !(iss_hit && (bus.iss_addr == ra)));
    end

    grf_scoreboard #(.AW(AW)) u_sb (
        .clk         (clk),
        .rst         (reset),
        .flush_i     (bus.pend_flush),
        .clr_valid_i (wr_commit),
        .clr_addr_i  (bus.wa),
        .set_valid_i (iss_hit),
        .set_addr_i  (bus.iss_addr),
        .pending_o   (pending),
        .pend_cnt_o  (bus.pend_cnt)
    );

    assign bus.log_valid = (LOG_EN != 0) && wr_commit;
    assign bus.log_pc    = bus.wpc;
    assign bus.log_addr  = bus.wa;
    assign bus.log_data  = merged_d;

endmodule

// File: tb/tb_grf_mp.sv
// tb/tb_grf_mp.sv - directed vector bench for grf_mp in default and wide configurations
module tb_grf_mp;

    logic clk;
    logic reset;

    grf_mp_if #(.DW(32), .AW(5), .NRD(2)) bus32 ();
    grf_mp_if #(.DW(64), .AW(4), .NRD(3)) bus64 ();

    grf_mp #(.DW(32), .AW(5), .NRD(2), .LOG_EN(1)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32)
    );

    grf_mp #(.DW(64), .AW(4), .NRD(3), .LOG_EN(0)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int log_cnt = 0;

    always @(posedge clk) begin
        if (bus32.log_valid) begin
            $display("@%h: $%0d <= %h", bus32.log_pc, bus32.log_addr, bus32.log_data);
            log_cnt++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  wbe;
        logic        iss;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic        e_b0;
        logic        e_b1;
        logic        e_log;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vt [16];

    initial begin
        vt[0]  = '{1'b1, 5'd5, 32'h12345678, 4'hF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b1, 6'd0};
        vt[1]  = '{1'b1, 5'd5, 32'hAABBCCDD, 4'h5, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5, 32'h12BB56DD, 32'h12BB56DD, 1'b0, 1'b0, 1'b1, 6'd0};
        vt[2]  = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 32'h12BB56DD, 32'h0,        1'b0, 1'b0, 1'b0, 6'd0};
        vt[3]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd5, 32'h0,        32'h12BB56DD, 1'b0, 1'b0, 1'b0, 6'd0};
        vt[4]  = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd7, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 6'd1};
        vt[5]  = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd7, 1'b0, 5'd3, 5'd7, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 6'd2};
        vt[6]  = '{1'b1, 5'd3, 32'h00000033, 4'hF, 1'b0, 5'd0, 1'b0, 5'd3, 5'd7, 32'h33,       32'h0,        1'b0, 1'b1, 1'b1, 6'd1};
        vt[7]  = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd7, 32'h33,       32'h0,        1'b0, 1'b1, 1'b0, 6'd1};
        vt[8]  = '{1'b1, 5'd9, 32'h00000099, 4'hF, 1'b1, 5'd9, 1'b0, 5'd9, 5'd7, 32'h99,       32'h0,        1'b0, 1'b1, 1'b1, 6'd2};
        vt[9]  = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd7, 32'h99,       32'h0,        1'b1, 1'b1, 1'b0, 6'd2};
        vt[10] = '{1'b1, 5'd9, 32'h000000AA, 4'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd7, 32'h99,       32'h0,        1'b1, 1'b1, 1'b0, 6'd2};
        vt[11] = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd4, 1'b1, 5'd4, 5'd9, 32'h0,        32'h99,       1'b0, 1'b1, 1'b0, 6'd0};
        vt[12] = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd9, 32'h0,        32'h99,       1'b0, 1'b0, 1'b0, 6'd1};
        vt[13] = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd9, 32'h0,        32'h99,       1'b1, 1'b0, 1'b0, 6'd1};
        vt[14] = '{1'b1, 5'd4, 32'h00004400, 4'h2, 1'b1, 5'd4, 1'b0, 5'd4, 5'd9, 32'h4400,     32'h99,       1'b1, 1'b0, 1'b1, 6'd1};
        vt[15] = '{1'b1, 5'd4, 32'h0,        4'hF, 1'b0, 5'd0, 1'b0, 5'd4, 5'd9, 32'h0,        32'h99,       1'b0, 1'b0, 1'b1, 6'd0};

        reset = 1'b1;
        bus32.rd_addr = '0; bus32.we = 1'b0; bus32.wa = '0; bus32.wd = '0; bus32.wbe = '0;
        bus32.wpc = '0; bus32.iss_valid = 1'b0; bus32.iss_addr = '0; bus32.pend_flush = 1'b0;
        bus64.rd_addr = '0; bus64.we = 1'b0; bus64.wa = '0; bus64.wd = '0; bus64.wbe = '0;
        bus64.wpc = '0; bus64.iss_valid = 1'b0; bus64.iss_addr = '0; bus64.pend_flush = 1'b0;
        tick();
        tick();
        bus32.rd_addr = {5'd5, 5'd31};
        #2;
        chk("reset_rd", 64'(bus32.rd_data), 64'h0);
        chk("reset_busy", 64'(bus32.rd_busy), 64'h0);
        chk("reset_cnt", 64'(bus32.pend_cnt), 64'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) begin
            bus32.we         = vt[i].we;
            bus32.wa         = vt[i].wa;
            bus32.wd         = vt[i].wd;
            bus32.wbe        = vt[i].wbe;
            bus32.wpc        = 32'h00400000 + 32'(i * 4);
            bus32.iss_valid  = vt[i].iss;
            bus32.iss_addr   = vt[i].ia;
            bus32.pend_flush = vt[i].fl;
            bus32.rd_addr    = {vt[i].ra1, vt[i].ra0};
            #2;
            chk($sformatf("v%0d_rd0", i), 64'(bus32.rd_data[31:0]), 64'(vt[i].e_rd0));
            chk($sformatf("v%0d_rd1", i), 64'(bus32.rd_data[63:32]), 64'(vt[i].e_rd1));
            chk($sformatf("v%0d_busy0", i), 64'(bus32.rd_busy[0]), 64'(vt[i].e_b0));
            chk($sformatf("v%0d_busy1", i), 64'(bus32.rd_busy[1]), 64'(vt[i].e_b1));
            chk($sformatf("v%0d_log", i), 64'(bus32.log_valid), 64'(vt[i].e_log));
            if (vt[i].e_log) begin
                chk($sformatf("v%0d_logdata", i), 64'(bus32.log_data), 64'(vt[i].e_rd0));
            end
            tick();
            chk($sformatf("v%0d_cnt", i), 64'(bus32.pend_cnt), 64'(vt[i].e_cnt));
        end
        bus32.we = 1'b0; bus32.iss_valid = 1'b0; bus32.pend_flush = 1'b0; bus32.wbe = '0;
        chk("trace_lines", 64'(log_cnt), 64'd6);

        // Stored state survives idle cycles
        bus32.rd_addr = {5'd3, 5'd5};
        #2;
        chk("stored_5", 64'(bus32.rd_data[31:0]), 64'h12BB56DD);
        chk("stored_3", 64'(bus32.rd_data[63:32]), 64'h33);

        // Asynchronous reset between edges
        bus32.iss_valid = 1'b1; bus32.iss_addr = 5'd3;
        tick();
        bus32.iss_valid = 1'b0;
        chk("pre_reset_cnt", 64'(bus32.pend_cnt), 64'd1);
        #1;
        bus32.we = 1'b1; bus32.wa = 5'd5; bus32.wd = 32'hDEADBEEF; bus32.wbe = 4'hF;
        bus32.rd_addr = {5'd9, 5'd5};
        #1;
        reset = 1'b1;
        #1;
        chk("areset_rd", 64'(bus32.rd_data), 64'h0);
        chk("areset_cnt", 64'(bus32.pend_cnt), 64'h0);
        chk("areset_busy", 64'(bus32.rd_busy), 64'h0);
        bus32.we = 1'b0;
        #1;
        reset = 1'b0;
        bus32.rd_addr = {5'd3, 5'd9};
        #1;
        chk("post_reset_rd", 64'(bus32.rd_data), 64'h0);
        tick();

        // Wide configuration: 8 byte enables, 3 independent ports
        bus64.we = 1'b1; bus64.wa = 4'd1; bus64.wd = 64'h1111111111111111; bus64.wbe = 8'hFF;
        tick();
        bus64.wa = 4'd15; bus64.wd = 64'h0123456789ABCDEF;
        tick();
        bus64.wd = 64'hFFFFFFFFFFFFFFFF; bus64.wbe = 8'hA5;
        bus64.rd_addr = {4'd0, 4'd1, 4'd15};
        #2;
        chk("w64_fwd_p0", bus64.rd_data[63:0], 64'hFF23FF6789FFCDFF);
        chk("w64_p1", bus64.rd_data[127:64], 64'h1111111111111111);
        chk("w64_p2_zero", bus64.rd_data[191:128], 64'h0);
        chk("w64_nolog", 64'(bus64.log_valid), 64'h0);
        tick();
        bus64.we = 1'b0; bus64.wbe = '0;
        bus64.rd_addr = {4'd15, 4'd1, 4'd15};
        #2;
        chk("w64_st_p0", bus64.rd_data[63:0], 64'hFF23FF6789FFCDFF);
        chk("w64_st_p1", bus64.rd_data[127:64], 64'h1111111111111111);
        chk("w64_st_p2", bus64.rd_data[191:128], 64'hFF23FF6789FFCDFF);

        for (int a = 1; a < 16; a++) begin
            bus64.iss_valid = 1'b1;
            bus64.iss_addr  = 4'(a);
            tick();
        end
        bus64.iss_addr = 4'd0;
        tick();
        bus64.iss_valid = 1'b0;
        bus64.rd_addr = {4'd0, 4'd1, 4'd15};
        #2;
        chk("w64_cnt_max", 64'(bus64.pend_cnt), 64'd15);
        chk("w64_busy", 64'(bus64.rd_busy), 64'b011);
        bus64.pend_flush = 1'b1;
        tick();
        bus64.pend_flush = 1'b0;
        chk("w64_flush_cnt", 64'(bus64.pend_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
